trigger_scheduler: RTL and testbench
====================================

TRIGGER_SCHEDULER -- requirements
Module: trigger_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of config words and command data.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, fetch-timeout limit; used only with TRIG_SCHED_TIMEOUT_EN.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rstn  in  1  asynchronous active-low reset.
REQ-005 i_trig  in  4  trigger source lines, level inputs, bit i = source i+1.
REQ-006 reg_rd_en  out  1  request for config read from the register file.
REQ-007 reg_rd_valid  in  1  configs valid, combinational response to reg_rd_en.
REQ-008 rd_trig_s1_config..rd_trig_s4_config  in  DATA_WIDTH each  per-source config words.
REQ-009 mst_o_valid  out  1  command valid toward the bus master.
REQ-010 mst_o_data  out  DATA_WIDTH  command word, equal to the granted source's config.
REQ-011 mst_o_src  out  2  index of the granted source, 0..3.
REQ-012 mst_i_ready  in  1  master accepts the command when high together with mst_o_valid.
REQ-013 o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 o_err  out  1  one-cycle pulse on fetch timeout; tied 0 without the macro.

Function
REQ-015 Rising edge detection: a registered copy of i_trig; bit i sets pending[i] when i_trig[i]=1 and the previous value was 0.
REQ-016 If a set and a clear of pending[i] occur in the same cycle, the set wins.
REQ-017 FSM states: IDLE, FETCH, ISSUE.
REQ-018 IDLE: if pending!=0, select the first pending index at or after (last_grant+1) mod 4, latch it as sel, and go to FETCH.
REQ-019 Round-robin wrap: the search runs 3 -> 0; last_grant resets to 3, so source 0 has first priority after reset.
REQ-020 FETCH: reg_rd_en=1, combinationally from the state; when reg_rd_valid=1, latch the config of sel.
REQ-021 FETCH with latched config==0: clear pending[sel], set last_grant=sel, go to IDLE, and issue no command.
REQ-022 FETCH with nonzero config: go to ISSUE.
REQ-023 ISSUE: mst_o_valid=1; mst_o_data and mst_o_src stay stable until mst_i_ready=1.
REQ-024 ISSUE handshake: clear pending[sel], set last_grant=sel, and go to IDLE the next cycle.
REQ-025 Latency: trigger edge sampled at cycle N; pending set at N+1; FETCH at N+2; earliest mst_o_valid at N+3 with reg_rd_valid and mst_i_ready already high.
REQ-026 Triggers arriving during FETCH or ISSUE are only recorded in pending; they never preempt the current grant.
REQ-027 Outside ISSUE: mst_o_valid=0, mst_o_data=0, mst_o_src=0.

Reset
REQ-028 On i_rstn low, asynchronously: state=IDLE, pending=0, edge register=0, last_grant=3, latched config=0, timeout counter=0.
REQ-029 On i_rstn low, asynchronously: all outputs 0.
REQ-030 Reset mid-FETCH or mid-ISSUE abandons the operation; pending triggers are lost.

Configuration
REQ-031 Macro TRIG_SCHED_TIMEOUT_EN defined: a counter runs in FETCH; if reg_rd_valid is still 0 after TIMEOUT_CYCLES cycles, clear pending[sel], set last_grant=sel, pulse o_err, and go to IDLE.
REQ-032 TRIG_SCHED_TIMEOUT_EN undefined: FETCH waits indefinitely for reg_rd_valid, there is no counter, and o_err=0.

Verification
REQ-033 Configs {A5,0,0,0}, pulse i_trig[0], mst_i_ready=1 -> mst_o_valid at N+3 with mst_o_data=A5 and mst_o_src=0, then IDLE.
REQ-034 All configs nonzero, i_trig=4'hF in one cycle -> grants in order 0,1,2,3, with a single-cycle mst_o_valid for each.
REQ-035 mst_i_ready held 0 for 5 cycles in ISSUE -> mst_o_valid, mst_o_data and mst_o_src stable for 5 cycles; accepted on cycle 6.
REQ-036 Config of source 2 = 0, pulse i_trig[2] -> FETCH then IDLE, no mst_o_valid, pending[2] cleared.
REQ-037 TRIG_SCHED_TIMEOUT_EN, all configs 0, pulse i_trig[1] -> o_err pulses after 16 FETCH cycles, FSM back in IDLE.
REQ-038 i_rstn low during ISSUE -> outputs 0 asynchronously; after release, no command is issued without a new trigger edge.

Source files
------------

// File: rtl/trigger_scheduler_if.sv
// trigger_scheduler_if: register-file read port and command port of the trigger scheduler.
// The master modport is the scheduler's view; slave is the register file / bus master side.
interface trigger_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  reg_rd_en;
  logic                  reg_rd_valid;
  logic [DATA_WIDTH-1:0] rd_trig_s1_config;
  logic [DATA_WIDTH-1:0] rd_trig_s2_config;
  logic [DATA_WIDTH-1:0] rd_trig_s3_config;
  logic [DATA_WIDTH-1:0] rd_trig_s4_config;
  logic                  mst_o_valid;
  logic [DATA_WIDTH-1:0] mst_o_data;
  logic [1:0]            mst_o_src;
  logic                  mst_i_ready;

  modport master (
    output reg_rd_en,
    input  reg_rd_valid,
    input  rd_trig_s1_config,
    input  rd_trig_s2_config,
    input  rd_trig_s3_config,
    input  rd_trig_s4_config,
    output mst_o_valid,
    output mst_o_data,
    output mst_o_src,
    input  mst_i_ready
  );

  modport slave (
    input  reg_rd_en,
    output reg_rd_valid,
    output rd_trig_s1_config,
    output rd_trig_s2_config,
    output rd_trig_s3_config,
    output rd_trig_s4_config,
    input  mst_o_valid,
    input  mst_o_data,
    input  mst_o_src,
    output mst_i_ready
  );
endinterface

// File: rtl/trigger_scheduler.sv
// trigger_scheduler: turns rising edges on four trigger lines into bus commands,
// granting pending sources round-robin and fetching each source's config word.
// Optional fetch timeout (o_err pulse) is enabled by defining TRIG_SCHED_TIMEOUT_EN.
module trigger_scheduler #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [3:0]          i_trig,
  trigger_scheduler_if.master bus,
  output logic                o_busy,
  output logic                o_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            trig_q, trig_d;
  logic [3:0]            pending_q, pending_d;
  logic [3:0]            pend_clr;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            rr_idx, rr_cand;
  logic                  rr_found;
  logic [DATA_WIDTH-1:0] cfg_q, cfg_d, cfg_sel;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("trigger_scheduler: TIMEOUT_CYCLES must be nonzero");
  end

`ifdef TRIG_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  // State and datapath registers, all asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      trig_q       <= '0;
      pending_q    <= '0;
      last_grant_q <= 2'd3;
      sel_q        <= '0;
      cfg_q        <= '0;
`ifdef TRIG_SCHED_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      cfg_q        <= cfg_d;
`ifdef TRIG_SCHED_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Round-robin search: first pending source after last_grant, wrapping 3 -> 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      rr_cand = last_grant_q + 2'(k);
      if (!rr_found && pending_q[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Config word of the currently selected source.
  always_comb begin
    case (sel_q)
      2'd0:    cfg_sel = bus.rd_trig_s1_config;
      2'd1:    cfg_sel = bus.rd_trig_s2_config;
      2'd2:    cfg_sel = bus.rd_trig_s3_config;
      default: cfg_sel = bus.rd_trig_s4_config;
    endcase
  end

  // Next-state logic; pending set from a new edge overrides a same-cycle clear.
  always_comb begin
    state_d      = state_q;
    trig_d       = i_trig;
    sel_d        = sel_q;
    cfg_d        = cfg_q;
    last_grant_d = last_grant_q;
    pend_clr     = '0;
`ifdef TRIG_SCHED_TIMEOUT_EN
    err_d        = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          sel_d   = rr_idx;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.reg_rd_valid) begin
          cfg_d = cfg_sel;
          if (cfg_sel == '0) begin
            pend_clr[sel_q] = 1'b1;
            last_grant_d    = sel_q;
            state_d         = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
`ifdef TRIG_SCHED_TIMEOUT_EN
        else if (to_cnt_q == CNT_LAST) begin
          pend_clr[sel_q] = 1'b1;
          last_grant_d    = sel_q;
          err_d           = 1'b1;
          state_d         = ST_IDLE;
        end
`endif
      end
      ST_ISSUE: begin
        if (bus.mst_i_ready) begin
          pend_clr[sel_q] = 1'b1;
          last_grant_d    = sel_q;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = (pending_q & ~pend_clr) | (i_trig & ~trig_q);
`ifdef TRIG_SCHED_TIMEOUT_EN
    to_cnt_d  = (state_q == ST_FETCH && state_d == ST_FETCH) ? to_cnt_q + 1'b1 : '0;
`endif
  end

  // Outputs decoded from the state; command fields are zero outside ISSUE.
  always_comb begin
    bus.reg_rd_en   = (state_q == ST_FETCH);
    bus.mst_o_valid = (state_q == ST_ISSUE);
    bus.mst_o_data  = '0;
    bus.mst_o_src   = '0;
    if (state_q == ST_ISSUE) begin
      bus.mst_o_data = cfg_q;
      bus.mst_o_src  = sel_q;
    end
    o_busy = (state_q != ST_IDLE);
`ifdef TRIG_SCHED_TIMEOUT_EN
    o_err  = err_q;
`else
    o_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_trigger_scheduler.sv
// tb_trigger_scheduler: directed scenarios plus randomized traffic checked against
// a grant-level reference model of the trigger scheduler.
module tb_trigger_scheduler;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic       i_clk  = 1'b0;
  logic       i_rstn = 1'b1;
  logic [3:0] i_trig = '0;
  logic       o_busy, o_err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  trigger_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  trigger_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_trig (i_trig),
    .bus    (bus),
    .o_busy (o_busy),
    .o_err  (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic set_cfg(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                         input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    bus.rd_trig_s1_config = c0;
    bus.rd_trig_s2_config = c1;
    bus.rd_trig_s3_config = c2;
    bus.rd_trig_s4_config = c3;
  endtask

  task automatic do_reset();
    i_rstn           = 1'b0;
    i_trig           = '0;
    bus.reg_rd_valid = 1'b1;
    bus.mst_i_ready  = 1'b1;
    tick();
    tick();
    i_rstn = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int unsigned limit);
    for (int unsigned i = 0; i < limit && bus.mst_o_valid !== 1'b1; i++) tick();
    chk(tag, bus.mst_o_valid, 1'b1);
  endtask

  // Reference model state (grant level).
  logic [DW-1:0] cfg [4];
  logic [DW-1:0] rr_cfg [4];
  int            m_job, m_last, idx;
  bit            m_offer, rv, exp_v;
  logic [3:0]    m_pend, m_prev, edges, clr;
  logic [DW-1:0] m_data;
  int unsigned   lows, n_grant, n_fetch;
  bit            prev_v, saw_v, saw_rd, saw_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.reg_rd_valid = 1'b0;
    bus.mst_i_ready  = 1'b0;
    set_cfg('0, '0, '0, '0);
    #1 i_rstn = 1'b0;
    #1;
    chk("rst_valid", bus.mst_o_valid, 1'b0);
    chk("rst_data",  bus.mst_o_data,  '0);
    chk("rst_src",   bus.mst_o_src,   '0);
    chk("rst_rden",  bus.reg_rd_en,   1'b0);
    chk("rst_busy",  o_busy,          1'b0);
    chk("rst_err",   o_err,           1'b0);
    do_reset();

    // Single trigger: command visible three edges after the sampling edge.
    set_cfg(32'hA5, '0, '0, '0);
    i_trig = 4'b0001;
    tick();
    i_trig = 4'b0000;
    chk("lat_n1_valid", bus.mst_o_valid, 1'b0);
    chk("lat_n1_busy",  o_busy,          1'b0);
    tick();
    chk("lat_n2_rden",  bus.reg_rd_en,   1'b1);
    chk("lat_n2_valid", bus.mst_o_valid, 1'b0);
    tick();
    chk("lat_n3_valid", bus.mst_o_valid, 1'b1);
    chk("lat_n3_data",  bus.mst_o_data,  32'hA5);
    chk("lat_n3_src",   bus.mst_o_src,   2'd0);
    tick();
    chk("lat_done_valid", bus.mst_o_valid, 1'b0);
    chk("lat_done_busy",  o_busy,          1'b0);

    // All four triggers at once: grants 0,1,2,3, each a single-cycle valid.
    do_reset();
    rr_cfg = '{32'h11, 32'h22, 32'h33, 32'h44};
    set_cfg(rr_cfg[0], rr_cfg[1], rr_cfg[2], rr_cfg[3]);
    i_trig = 4'hF;
    tick();
    i_trig  = 4'h0;
    n_grant = 0;
    prev_v  = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (bus.mst_o_valid === 1'b1) begin
        chk("rr_src",    bus.mst_o_src,  2'(n_grant));
        chk("rr_data",   bus.mst_o_data, rr_cfg[n_grant & 3]);
        chk("rr_single", prev_v,         1'b0);
        n_grant++;
      end
      prev_v = bus.mst_o_valid;
      tick();
    end
    chk("rr_count", n_grant, 4);

    // Back-pressure: command held stable for 5 cycles, accepted on the 6th.
    do_reset();
    bus.mst_i_ready = 1'b0;
    i_trig = 4'b0010;
    tick();
    i_trig = 4'b0000;
    wait_valid("stall_wait", 8);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", bus.mst_o_valid, 1'b1);
      chk("stall_data",  bus.mst_o_data,  32'h22);
      chk("stall_src",   bus.mst_o_src,   2'd1);
      tick();
    end
    bus.mst_i_ready = 1'b1;
    chk("acc_valid", bus.mst_o_valid, 1'b1);
    chk("acc_src",   bus.mst_o_src,   2'd1);
    tick();
    chk("acc_done", bus.mst_o_valid, 1'b0);

    // Zero config: fetch happens, no command, pending bit is dropped.
    do_reset();
    set_cfg(32'h11, 32'h22, '0, 32'h44);
    i_trig = 4'b0100;
    tick();
    i_trig = 4'b0000;
    saw_rd = 1'b0;
    saw_v  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.reg_rd_en === 1'b1) saw_rd = 1'b1;
      if (bus.mst_o_valid === 1'b1) saw_v = 1'b1;
      tick();
    end
    chk("zero_fetch",   saw_rd, 1'b1);
    chk("zero_novalid", saw_v,  1'b0);
    chk("zero_idle",    o_busy, 1'b0);
    set_cfg(32'h11, 32'h22, 32'h33, 32'h44);
    for (int c = 0; c < 6; c++) begin
      if (bus.mst_o_valid === 1'b1) saw_v = 1'b1;
      tick();
    end
    chk("zero_cleared", saw_v,  1'b0);
    chk("zero_cleared_busy", o_busy, 1'b0);

`ifdef TRIG_SCHED_TIMEOUT_EN
    // Fetch timeout: register file never answers.
    do_reset();
    set_cfg('0, '0, '0, '0);
    bus.reg_rd_valid = 1'b0;
    i_trig = 4'b0010;
    tick();
    i_trig  = 4'b0000;
    n_fetch = 0;
    saw_err = 1'b0;
    for (int c = 0; c < 40 && !saw_err; c++) begin
      tick();
      if (o_err === 1'b1) saw_err = 1'b1;
      else if (bus.reg_rd_en === 1'b1) n_fetch++;
    end
    chk("to_err",          saw_err, 1'b1);
    chk("to_fetch_cycles", n_fetch, TO);
    chk("to_idle",         o_busy,  1'b0);
    tick();
    chk("to_err_pulse",    o_err,   1'b0);
    bus.reg_rd_valid = 1'b1;
`endif

    // Reset during ISSUE: outputs drop immediately, pending work is lost.
    do_reset();
    bus.mst_i_ready = 1'b0;
    set_cfg(32'h11, 32'h22, 32'h33, 32'h44);
    i_trig = 4'b0011;
    tick();
    i_trig = 4'b0000;
    wait_valid("rstm_wait", 8);
    #2 i_rstn = 1'b0;
    #1;
    chk("rstm_valid", bus.mst_o_valid, 1'b0);
    chk("rstm_data",  bus.mst_o_data,  '0);
    chk("rstm_src",   bus.mst_o_src,   '0);
    chk("rstm_rden",  bus.reg_rd_en,   1'b0);
    chk("rstm_busy",  o_busy,          1'b0);
    tick();
    tick();
    i_rstn          = 1'b1;
    bus.mst_i_ready = 1'b1;
    saw_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.mst_o_valid === 1'b1 || o_busy === 1'b1) saw_v = 1'b1;
      tick();
    end
    chk("rstm_no_cmd", saw_v, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    m_job   = -1;
    m_offer = 1'b0;
    m_pend  = '0;
    m_prev  = '0;
    m_last  = 3;
    m_data  = '0;
    lows    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_v = (m_job >= 0) && m_offer;
      chk("rnd_valid", bus.mst_o_valid, exp_v);
      chk("rnd_data",  bus.mst_o_data,  exp_v ? m_data : '0);
      chk("rnd_src",   bus.mst_o_src,   exp_v ? 2'(m_job) : 2'd0);
      chk("rnd_rden",  bus.reg_rd_en,   (m_job >= 0) && !m_offer);
      chk("rnd_busy",  o_busy,          m_job >= 0);
      chk("rnd_err",   o_err,           1'b0);

      if ($urandom_range(0, 9) < 3) i_trig = 4'($urandom_range(0, 15));
      bus.mst_i_ready = ($urandom_range(0, 9) < 6);
      rv   = (lows >= 4) ? 1'b1 : ($urandom_range(0, 9) < 7);
      lows = rv ? 0 : lows + 1;
      bus.reg_rd_valid = rv;
      for (int i = 0; i < 4; i++) cfg[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      set_cfg(cfg[0], cfg[1], cfg[2], cfg[3]);

      // Effect of the coming clock edge on the model.
      edges = i_trig & ~m_prev;
      clr   = '0;
      if (m_job < 0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (m_job < 0 && m_pend[idx]) m_job = idx;
        end
        m_offer = 1'b0;
      end else if (!m_offer) begin
        if (rv) begin
          if (cfg[m_job] == '0) begin
            clr[m_job] = 1'b1;
            m_last     = m_job;
            m_job      = -1;
          end else begin
            m_offer = 1'b1;
            m_data  = cfg[m_job];
          end
        end
      end else if (bus.mst_i_ready) begin
        clr[m_job] = 1'b1;
        m_last     = m_job;
        m_job      = -1;
      end
      m_pend = (m_pend & ~clr) | edges;
      m_prev = i_trig;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
